// File: rtl/dat_tx_framer_pkg.sv
// Shared types and constants for the SD DAT write-path framer.
package dat_tx_framer_pkg;

   localparam int          BLOCK_SZ_WIDTH = 12;
   localparam int          NIB_CNT_WIDTH  = BLOCK_SZ_WIDTH + 1;
   localparam int          FRAMER_STATE_W = 8;
   localparam logic [15:0] CRC16_POLY     = 16'h1021;
   localparam logic [2:0]  STAT_TOKEN_OK  = 3'b010;

   typedef enum logic [FRAMER_STATE_W-1:0] {
      ST_IDLE      = 8'b0000_0001,
      ST_START     = 8'b0000_0010,
      ST_DATA      = 8'b0000_0100,
      ST_CRC       = 8'b0000_1000,
      ST_END       = 8'b0001_0000,
      ST_STAT_WAIT = 8'b0010_0000,
      ST_STAT      = 8'b0100_0000,
      ST_BUSY      = 8'b1000_0000
   } framer_state_t;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
      logic fb;
      fb = crc[15] ^ bit_in;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/dat_tx_framer_crc16.sv
// Bit-serial CRC16-CCITT (init 0), one instance per DAT line.
module sd_crc16
   import dat_tx_framer_pkg::*;
(
   input  logic        sd_clk,
   input  logic        rst_L,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   always_ff @(posedge sd_clk or negedge rst_L) begin
      if (!rst_L)
         crc <= '0;
      else if (clr)
         crc <= '0;
      else if (en)
         crc <= crc16_step(crc, bit_in);
   end

endmodule

// File: rtl/dat_tx_framer.sv
// Frames one write block onto DAT[3:0] (start, data, per-line CRC16, end)
// and collects the card's CRC-status token and busy release.
module dat_tx_framer
   import dat_tx_framer_pkg::*;
#(
   parameter int unsigned STAT_TIMEOUT = 8,
   parameter int unsigned BUSY_TIMEOUT = 65535
) (
   input  logic                      sd_clk,
   input  logic                      rst_L,
   input  logic                      start,
   input  logic [BLOCK_SZ_WIDTH-1:0] block_sz,
   input  logic [3:0]                nib_din,
   input  logic                      nib_valid,
   output logic                      nib_ready,
   input  logic [3:0]                DAT_din,
   output logic [3:0]                DAT_dout,
   output logic                      DAT_oe,
   output logic                      framer_busy,
   output logic                      blk_done,
   output logic                      crc_ok,
   output logic                      crc_err,
   output logic                      timeout_err,
   output logic                      underrun_err
);

   framer_state_t            state;
   logic [NIB_CNT_WIDTH-1:0] nib_left;
   logic [15:0]              cnt;
   logic [2:0]               token;
   logic                     status_good;
   logic [15:0]              crc_q [4];
   logic [3:0]               crc_msb;
   logic [3:0]               crc_sel;
   logic [3:0]               bit_idx;
   logic                     crc_clr;
   logic                     nib_take;
   logic                     last_nib;
   logic                     din_unused;

   always_comb begin
      nib_ready   = (state == ST_START) ||
                    ((state == ST_DATA) && (|nib_left[NIB_CNT_WIDTH-1:1]));
      framer_busy = (state != ST_IDLE);
      nib_take    = nib_valid && nib_ready;
      last_nib    = (nib_left == NIB_CNT_WIDTH'(1));
      crc_clr     = (state == ST_IDLE);
      bit_idx     = cnt[3:0] - 4'd1;
      din_unused  = ^DAT_din[3:1];
      for (int unsigned i = 0; i < 4; i++) begin
         crc_msb[i] = crc_q[i][15];
         crc_sel[i] = crc_q[i][bit_idx];
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_line
      sd_crc16 u_crc (
         .sd_clk (sd_clk),
         .rst_L  (rst_L),
         .clr    (crc_clr),
         .en     (nib_take),
         .bit_in (nib_din[g]),
         .crc    (crc_q[g])
      );
   end

   always_ff @(posedge sd_clk or negedge rst_L) begin
      if (!rst_L) begin
         state        <= ST_IDLE;
         nib_left     <= '0;
         cnt          <= '0;
         token        <= '0;
         status_good  <= 1'b0;
         DAT_dout     <= '1;
         DAT_oe       <= 1'b0;
         blk_done     <= 1'b0;
         crc_ok       <= 1'b0;
         crc_err      <= 1'b0;
         timeout_err  <= 1'b0;
         underrun_err <= 1'b0;
      end else begin
         blk_done     <= 1'b0;
         crc_ok       <= 1'b0;
         crc_err      <= 1'b0;
         timeout_err  <= 1'b0;
         underrun_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && (block_sz != '0)) begin
                  nib_left <= {block_sz, 1'b0};
                  DAT_dout <= '0;
                  DAT_oe   <= 1'b1;
                  state    <= ST_START;
               end
            end
            ST_START, ST_DATA: begin
               // nib_left only counts down in DATA; its final value of 1 marks
               // the cycle that drives the last nibble without taking another.
               if ((state == ST_DATA) && last_nib) begin
                  DAT_dout <= crc_msb;
                  cnt      <= 16'd15;
                  state    <= ST_CRC;
               end else if (!nib_valid) begin
                  DAT_dout     <= '1;
                  DAT_oe       <= 1'b0;
                  blk_done     <= 1'b1;
                  underrun_err <= 1'b1;
                  state        <= ST_IDLE;
               end else begin
                  DAT_dout <= nib_din;
                  if (state == ST_DATA)
                     nib_left <= nib_left - 1'b1;
                  state <= ST_DATA;
               end
            end
            ST_CRC: begin
               // CRC registers hold still here; bits are picked MSB first by index.
               if (cnt != '0) begin
                  DAT_dout <= crc_sel;
                  cnt      <= cnt - 1'b1;
               end else begin
                  DAT_dout <= '1;
                  state    <= ST_END;
               end
            end
            ST_END: begin
               DAT_oe <= 1'b0;
               cnt    <= '0;
               state  <= ST_STAT_WAIT;
            end
            ST_STAT_WAIT: begin
               if (!DAT_din[0]) begin
                  cnt   <= '0;
                  state <= ST_STAT;
               end else if (cnt == 16'(STAT_TIMEOUT - 1)) begin
                  blk_done    <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_STAT: begin
               if (cnt == 16'd3) begin
                  status_good <= (token == STAT_TOKEN_OK) && DAT_din[0];
                  cnt         <= '0;
                  state       <= ST_BUSY;
               end else begin
                  token <= {token[1:0], DAT_din[0]};
                  cnt   <= cnt + 1'b1;
               end
            end
            ST_BUSY: begin
               if (DAT_din[0]) begin
                  blk_done <= 1'b1;
                  crc_ok   <= status_good;
                  crc_err  <= !status_good;
                  state    <= ST_IDLE;
               end else if (cnt == 16'(BUSY_TIMEOUT)) begin
                  blk_done    <= 1'b1;
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dat_tx_framer.sv
// Self-checking bench for dat_tx_framer: cycle traces versus a block-level model.
`timescale 1ns/1ps
module tb_dat_tx_framer;
   import dat_tx_framer_pkg::*;

   localparam int unsigned ST   = 8;
   localparam int unsigned BT   = 40;
   localparam int          MAXC = 320;
   localparam logic [11:0] IDLE_VEC = 12'b0_1111_000_0000;

   logic                      sd_clk    = 1'b0;
   logic                      rst_L     = 1'b0;
   logic                      start     = 1'b0;
   logic [BLOCK_SZ_WIDTH-1:0] block_sz  = '0;
   logic [3:0]                nib_din   = '0;
   logic                      nib_valid = 1'b0;
   logic                      nib_ready;
   logic [3:0]                DAT_din   = 4'hF;
   logic [3:0]                DAT_dout;
   logic                      DAT_oe, framer_busy, blk_done;
   logic                      crc_ok, crc_err, timeout_err, underrun_err;

   int checks = 0;
   int errors = 0;

   logic [3:0]  nibs    [64];
   logic [11:0] obs_vec [MAXC];
   logic [11:0] exp_vec [MAXC];
   int          ncyc;

   dat_tx_framer #(.STAT_TIMEOUT(ST), .BUSY_TIMEOUT(BT)) dut (
      .sd_clk(sd_clk), .rst_L(rst_L), .start(start), .block_sz(block_sz),
      .nib_din(nib_din), .nib_valid(nib_valid), .nib_ready(nib_ready),
      .DAT_din(DAT_din), .DAT_dout(DAT_dout), .DAT_oe(DAT_oe),
      .framer_busy(framer_busy), .blk_done(blk_done), .crc_ok(crc_ok),
      .crc_err(crc_err), .timeout_err(timeout_err), .underrun_err(underrun_err)
   );

   always #5 sd_clk = ~sd_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [11:0] cur_vec();
      return {DAT_oe, DAT_dout, nib_ready, framer_busy, blk_done,
              crc_ok, crc_err, timeout_err, underrun_err};
   endfunction

   // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
   function automatic logic [15:0] line_crc(input int bs, input int line);
      logic [16:0] r = '0;
      for (int k = 0; k < 2*bs + 16; k++) begin
         r = {r[15:0], (k < 2*bs) ? nibs[k][line] : 1'b0};
         if (r[16]) r = r ^ 17'h11021;
      end
      return r[15:0];
   endfunction

   task automatic build_expect(input int bs, input int drop, input int lat, input bit no_tok,
                               input logic [2:0] tok, input logic endb, input int busy_n);
      int d_cyc, e, s;
      logic [3:0] flags, dout;
      logic [15:0] crcs [4];
      logic oe;
      e = 2*bs + 17;
      s = e + 1 + lat;
      if (drop >= 0) begin
         d_cyc = drop + 1; flags = 4'b0001;
      end else if (no_tok) begin
         d_cyc = e + ST + 1; flags = 4'b0010;
      end else if (busy_n > BT) begin
         d_cyc = s + 6 + BT; flags = 4'b0010;
      end else begin
         d_cyc = s + 6 + busy_n;
         flags = (tok == 3'b010 && endb) ? 4'b1000 : 4'b0100;
      end
      for (int i = 0; i < 4; i++) crcs[i] = line_crc(bs, i);
      ncyc = d_cyc + 2;
      for (int c = 0; c < ncyc; c++) begin
         oe = 1'b0; dout = 4'hF;
         if (drop < 0 || c <= drop) begin
            if (c == 0) begin oe = 1'b1; dout = 4'h0; end
            else if (c <= 2*bs) begin oe = 1'b1; dout = nibs[c-1]; end
            else if (c <= 2*bs + 16) begin
               oe = 1'b1;
               for (int i = 0; i < 4; i++) dout[i] = crcs[i][15 - (c - 2*bs - 1)];
            end else if (c == 2*bs + 17) begin oe = 1'b1; dout = 4'hF; end
         end
         exp_vec[c] = {oe, dout, (c <= 2*bs - 1) && (c < d_cyc), c < d_cyc, c == d_cyc,
                       (c == d_cyc) ? flags : 4'b0000};
      end
   endtask

   // Starts a block (caller is just past a negedge) and records one vector per cycle.
   task automatic drive_block(input int bs, input int drop, input int lat, input bit no_tok,
                              input logic [2:0] tok, input logic endb, input int busy_n,
                              input int stray);
      int s;
      logic cb;
      build_expect(bs, drop, lat, no_tok, tok, endb, busy_n);
      s = 2*bs + 18 + lat;
      block_sz = BLOCK_SZ_WIDTH'(bs);
      start = 1'b1;
      nib_valid = 1'b0;
      @(posedge sd_clk);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge sd_clk);
         obs_vec[c] = cur_vec();
         start = (c == stray);
         block_sz = start ? BLOCK_SZ_WIDTH'($urandom_range(1, 8)) : BLOCK_SZ_WIDTH'($urandom);
         if (c < 2*bs) begin
            nib_valid = (c != drop);
            nib_din = nibs[c];
         end else begin
            nib_valid = 1'($urandom_range(0, 1));
            nib_din = 4'($urandom);
         end
         if (no_tok || c < s) cb = 1'b1;
         else if (c == s) cb = 1'b0;
         else if (c <= s + 3) cb = tok[2 - (c - s - 1)];
         else if (c == s + 4) cb = endb;
         else if (c <= s + 4 + busy_n) cb = 1'b0;
         else cb = 1'b1;
         DAT_din = {3'($urandom), cb};
      end
      start = 1'b0; nib_valid = 1'b0; DAT_din = 4'hF;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge sd_clk);
   endtask

   task automatic test_reset();
      idle_cycles(3);
      checks++;
      if (cur_vec() !== IDLE_VEC) begin
         errors++; $display("FAIL reset_hold: got %b want %b", cur_vec(), IDLE_VEC);
      end
      rst_L = 1'b1;
      idle_cycles(2);
      checks++;
      if (cur_vec() !== IDLE_VEC) begin
         errors++; $display("FAIL reset_release: got %b want %b", cur_vec(), IDLE_VEC);
      end
   endtask

   task automatic test_basic();
      nibs[0] = 4'hA; nibs[1] = 4'h5;
      drive_block(1, -1, 2, 1'b0, 3'b010, 1'b1, 3, -1);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL basic cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_zero_crc_err();
      for (int k = 0; k < 8; k++) nibs[k] = 4'h0;
      drive_block(4, -1, 0, 1'b0, 3'b101, 1'b1, 2, -1);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL zero_crc_err cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      idle_cycles(2);
      nibs[0] = 4'h3; nibs[1] = 4'hC;
      drive_block(1, -1, 1, 1'b0, 3'b010, 1'b0, 1, -1);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL no_end_bit cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_stat_timeout();
      for (int k = 0; k < 4; k++) nibs[k] = 4'($urandom);
      drive_block(2, -1, 0, 1'b1, 3'b000, 1'b1, 0, -1);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL stat_timeout cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      idle_cycles(2);
      drive_block(2, -1, ST - 1, 1'b0, 3'b010, 1'b1, 0, -1);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL stat_late_ok cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_busy_timeout();
      for (int n = BT; n <= BT + 1; n++) begin
         nibs[0] = 4'($urandom); nibs[1] = 4'($urandom);
         drive_block(1, -1, 3, 1'b0, 3'b010, 1'b1, n, -1);
         for (int c = 0; c < ncyc; c++) begin
            checks++;
            if (obs_vec[c] !== exp_vec[c]) begin
               errors++; $display("FAIL busy_%0d cyc %0d: got %b want %b", n, c, obs_vec[c], exp_vec[c]);
            end
         end
         idle_cycles(2);
      end
   endtask

   task automatic test_underrun();
      for (int k = 0; k < 4; k++) nibs[k] = 4'($urandom);
      drive_block(2, 2, 0, 1'b1, 3'b000, 1'b1, 0, -1);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL underrun cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      nibs[0] = 4'h6; nibs[1] = 4'h9;
      drive_block(1, -1, 0, 1'b0, 3'b010, 1'b1, 1, -1);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL after_underrun cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_reset_mid_crc();
      for (int k = 0; k < 4; k++) nibs[k] = 4'($urandom);
      block_sz = BLOCK_SZ_WIDTH'(2);
      start = 1'b1;
      @(posedge sd_clk);
      for (int c = 0; c <= 9; c++) begin
         @(negedge sd_clk);
         start = 1'b0;
         nib_valid = (c < 4);
         nib_din = nibs[c % 4];
      end
      checks++;
      if (DAT_oe !== 1'b1 || framer_busy !== 1'b1) begin
         errors++; $display("FAIL crc_phase_active: got oe %b busy %b want 1 1", DAT_oe, framer_busy);
      end
      rst_L = 1'b0;
      #1;
      checks++;
      if (cur_vec() !== IDLE_VEC) begin
         errors++; $display("FAIL reset_mid_crc: got %b want %b", cur_vec(), IDLE_VEC);
      end
      nib_valid = 1'b0;
      idle_cycles(2);
      rst_L = 1'b1;
      idle_cycles(2);
      for (int k = 0; k < 4; k++) nibs[k] = 4'($urandom);
      drive_block(2, -1, 1, 1'b0, 3'b010, 1'b1, 2, -1);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL after_reset cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_ignored_starts();
      block_sz = '0;
      start = 1'b1;
      @(negedge sd_clk);
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (cur_vec() !== IDLE_VEC) begin
            errors++; $display("FAIL zero_size_start cyc %0d: got %b want %b", c, cur_vec(), IDLE_VEC);
         end
         @(negedge sd_clk);
      end
      for (int k = 0; k < 6; k++) nibs[k] = 4'($urandom);
      drive_block(3, -1, 0, 1'b0, 3'b010, 1'b1, 0, 3);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (obs_vec[c] !== exp_vec[c]) begin
            errors++; $display("FAIL stray_start cyc %0d: got %b want %b", c, obs_vec[c], exp_vec[c]);
         end
      end
      idle_cycles(2);
   endtask

   task automatic test_random();
      int bs, lat, busy_n, stray;
      logic [2:0] tok;
      logic endb;
      for (int it = 0; it < 8; it++) begin
         bs     = $urandom_range(1, 32);
         lat    = $urandom_range(0, ST - 1);
         busy_n = $urandom_range(0, 10);
         tok    = ($urandom_range(0, 2) != 0) ? 3'b010 : 3'($urandom);
         endb   = ($urandom_range(0, 3) != 0);
         stray  = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 2*bs) : -1;
         for (int k = 0; k < 2*bs; k++) nibs[k] = 4'($urandom);
         drive_block(bs, -1, lat, 1'b0, tok, endb, busy_n, stray);
         for (int c = 0; c < ncyc; c++) begin
            checks++;
            if (obs_vec[c] !== exp_vec[c]) begin
               errors++;
               $display("FAIL random%0d bs %0d cyc %0d: got %b want %b", it, bs, c, obs_vec[c], exp_vec[c]);
            end
         end
         idle_cycles($urandom_range(1, 3));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_crc_err();
      test_stat_timeout();
      test_busy_timeout();
      test_underrun();
      test_reset_mid_crc();
      test_ignored_starts();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
